lock_sequencer: RTL and testbench

Sequencing controller for the canal lock. It owns the lock-chamber water level and the outer and inner port (gate) enables. It takes gondola arrive and depart requests and walks each one through equalise, open, equalise, open. It arbitrates simultaneous requests and guarantees a port never opens against a level mismatch. It sits between the switch/key inputs and the seven-segment and LED display logic in the lab 2 top level.

---
 rtl/lock_sequencer.sv | 143 ++++++++++++++
 tb/tb_lock_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// Canal lock sequencer: equalises the chamber level against each side in turn and
// opens the matching port, arbitrating arrive/depart requests with a toggling priority.
module lock_sequencer #(
  parameter int unsigned LEVEL_W     = 14,
  parameter int unsigned STEP        = 1,
  parameter int unsigned DWELL       = 4,
  parameter int unsigned RESET_LEVEL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               arrive_req,
  input  logic               depart_req,
  input  logic [LEVEL_W-1:0] outside_level,
  input  logic [LEVEL_W-1:0] inner_level,
  output logic [LEVEL_W-1:0] lock_level,
  output logic               outer_open,
  output logic               inner_open,
  output logic               busy,
  output logic               dir,
  output logic               filling,
  output logic               draining,
  output logic               done
);

  localparam int unsigned DwellW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [2:0] {StIdle, StEq1, StOpen1, StEq2, StOpen2, StDone} state_e;

  state_e              state_q, state_d;
  logic [LEVEL_W-1:0]  lock_level_q, lock_level_d;
  logic [DwellW-1:0]   dwell_q, dwell_d;
  logic                dir_q, dir_d;
  logic                prio_q, prio_d;  // 1 = arrive wins the next tie
  logic                outer_open_q, outer_open_d;
  logic                inner_open_q, inner_open_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                phase2;
  logic                side_outer;
  logic                in_eq;
  logic [LEVEL_W-1:0]  target;
  logic [LEVEL_W-1:0]  diff;

  always_comb begin
    phase2     = (state_q == StEq2) || (state_q == StOpen2);
    side_outer = dir_q ^ phase2;
    target     = side_outer ? outside_level : inner_level;
    in_eq      = (state_q == StEq1) || (state_q == StEq2);
    diff       = (target > lock_level_q) ? (target - lock_level_q) : (lock_level_q - target);
    filling    = in_eq && (target > lock_level_q);
    draining   = in_eq && (target < lock_level_q);
  end

  always_comb begin
    state_d      = state_q;
    lock_level_d = lock_level_q;
    dwell_d      = '0;
    dir_d        = dir_q;
    prio_d       = prio_q;

    case (state_q)
      StIdle: begin
        if (arrive_req && depart_req) begin
          dir_d   = prio_q;
          prio_d  = ~prio_q;
          state_d = StEq1;
        end else if (arrive_req) begin
          dir_d   = 1'b1;
          state_d = StEq1;
        end else if (depart_req) begin
          dir_d   = 1'b0;
          state_d = StEq1;
        end
      end
      StEq1, StEq2: begin
        if (lock_level_q == target) begin
          state_d = (state_q == StEq1) ? StOpen1 : StOpen2;
        end else if (tick) begin
          // Clamp the final step so the level lands exactly on target.
          if (32'(diff) <= STEP) begin
            lock_level_d = target;
          end else if (target > lock_level_q) begin
            lock_level_d = lock_level_q + LEVEL_W'(STEP);
          end else begin
            lock_level_d = lock_level_q - LEVEL_W'(STEP);
          end
        end
      end
      StOpen1, StOpen2: begin
        lock_level_d = target;
        dwell_d      = dwell_q;
        if (tick) begin
          if (dwell_q == DwellW'(DWELL - 1)) begin
            state_d = (state_q == StOpen1) ? StEq2 : StDone;
          end else begin
            dwell_d = dwell_q + DwellW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    outer_open_d = ((state_d == StOpen1) && dir_d) || ((state_d == StOpen2) && !dir_d);
    inner_open_d = ((state_d == StOpen1) && !dir_d) || ((state_d == StOpen2) && dir_d);
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      lock_level_q <= LEVEL_W'(RESET_LEVEL);
      dwell_q      <= '0;
      dir_q        <= 1'b1;
      prio_q       <= 1'b1;
      outer_open_q <= 1'b0;
      inner_open_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_level_q <= lock_level_d;
      dwell_q      <= dwell_d;
      dir_q        <= dir_d;
      prio_q       <= prio_d;
      outer_open_q <= outer_open_d;
      inner_open_q <= inner_open_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign lock_level = lock_level_q;
  assign outer_open = outer_open_q;
  assign inner_open = inner_open_q;
  assign busy       = busy_q;
  assign dir        = dir_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: trace table, hand-written corner sequences, then random
// stimulus compared against a sequential transit model.
module tb_lock_sequencer;

  localparam int LW     = 14;
  localparam int TB_STEP  = 1;
  localparam int TB_DWELL = 4;

  logic          clk, rst, tick, arrive_req, depart_req;
  logic [LW-1:0] outside_level, inner_level, lock_level;
  logic          outer_open, inner_open, busy, dir, filling, draining, done;

  logic          t4_tick, t4_arrive, t4_depart;
  logic [LW-1:0] t4_out, t4_in, q4_lock;
  logic          q4_outer, q4_inner, q4_busy, q4_dir, q4_fill, q4_drain, q4_done;

  int n_vec = 0;
  int n_bad = 0;

  lock_sequencer #(.LEVEL_W(LW), .STEP(TB_STEP), .DWELL(TB_DWELL), .RESET_LEVEL(0)) dut (
    .clk(clk), .rst(rst), .tick(tick), .arrive_req(arrive_req), .depart_req(depart_req),
    .outside_level(outside_level), .inner_level(inner_level), .lock_level(lock_level),
    .outer_open(outer_open), .inner_open(inner_open), .busy(busy), .dir(dir),
    .filling(filling), .draining(draining), .done(done)
  );

  lock_sequencer #(.LEVEL_W(LW), .STEP(4), .DWELL(2), .RESET_LEVEL(0)) dut4 (
    .clk(clk), .rst(rst), .tick(t4_tick), .arrive_req(t4_arrive), .depart_req(t4_depart),
    .outside_level(t4_out), .inner_level(t4_in), .lock_level(q4_lock),
    .outer_open(q4_outer), .inner_open(q4_inner), .busy(q4_busy), .dir(q4_dir),
    .filling(q4_fill), .draining(q4_drain), .done(q4_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out, got 0 required 1 at %0t", name, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Trace table record: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic arr, dep, tk;
    int   lock;
    logic outer, inner, busy, dn, fill, drain;
  } vec_t;

  function automatic vec_t mk(logic a, logic d, logic t, int l, logic o, logic i, logic b,
                              logic dn, logic f, logic dr);
    vec_t v;
    v.arr = a; v.dep = d; v.tk = t; v.lock = l; v.outer = o; v.inner = i;
    v.busy = b; v.dn = dn; v.fill = f; v.drain = dr;
    return v;
  endfunction

  vec_t tbl[20];

  // Sequential transit model used for the random phase.
  int m_lock;
  bit m_dir, m_prio_arr, m_outer, m_inner, m_busy, m_done, m_eq, m_ph2;

  function automatic int side_lvl(bit outer);
    return outer ? int'(outside_level) : int'(inner_level);
  endfunction

  task automatic model_run();
    int tgt, d, ad, ticks;
    m_lock = 0; m_dir = 1; m_prio_arr = 1;
    m_outer = 0; m_inner = 0; m_busy = 0; m_done = 0; m_eq = 0; m_ph2 = 0;
    forever begin
      @(posedge clk);
      if (arrive_req || depart_req) begin
        if (arrive_req && depart_req) begin
          m_dir = m_prio_arr;
          m_prio_arr = !m_prio_arr;
        end else begin
          m_dir = arrive_req;
        end
        m_busy = 1;
        for (int ph = 0; ph < 2; ph++) begin
          m_ph2 = (ph == 1);
          m_eq = 1;
          forever begin
            @(posedge clk);
            tgt = side_lvl(m_dir ^ m_ph2);
            if (m_lock == tgt) break;
            if (tick) begin
              d  = tgt - m_lock;
              ad = (d < 0) ? -d : d;
              if (ad <= TB_STEP) m_lock = tgt;
              else m_lock = m_lock + ((d > 0) ? TB_STEP : -TB_STEP);
            end
          end
          m_eq = 0;
          if (m_dir ^ m_ph2) m_outer = 1;
          else m_inner = 1;
          ticks = 0;
          forever begin
            @(posedge clk);
            m_lock = side_lvl(m_dir ^ m_ph2);
            if (tick) ticks++;
            if (ticks == TB_DWELL) break;
          end
          m_outer = 0;
          m_inner = 0;
        end
        m_done = 1;
        @(posedge clk);
        m_done = 0;
        m_busy = 0;
      end
    end
  endtask

  initial begin
    int n;
    rst = 1; tick = 0; arrive_req = 0; depart_req = 0;
    outside_level = 5; inner_level = 2;
    t4_tick = 0; t4_arrive = 0; t4_depart = 0; t4_out = 10; t4_in = 10;
    #12;
    chk("rst_lock", lock_level, 0);
    chk("rst_outer", outer_open, 0);
    chk("rst_inner", inner_open, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dir", dir, 1);
    chk("rst_fill", filling, 0);
    chk("rst_drain", draining, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 0;

    // STEP=4 clamp with tick gaps, then a downward clamp on the way out.
    t4_arrive = 1; cyc(); t4_arrive = 0;
    chk("c4_eq_lock", q4_lock, 0);
    chk("c4_eq_fill", q4_fill, 1);
    t4_tick = 1; cyc(); chk("c4_step1", q4_lock, 4);
    t4_tick = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("c4_hold", q4_lock, 4);
    end
    t4_tick = 1; cyc(); chk("c4_step2", q4_lock, 8);
    cyc(); chk("c4_clamp10", q4_lock, 10);
    t4_tick = 0; cyc(); chk("c4_open_notick", q4_outer, 1);
    t4_tick = 1;
    n = 0;
    while (q4_done !== 1'b1 && n < 50) begin cyc(); n++; end
    if (n >= 50) timeout("c4_done");
    cyc(); chk("c4_idle", q4_busy, 0);
    t4_out = 1; t4_depart = 1; cyc(); t4_depart = 0;
    chk("c4_dep_dir", q4_dir, 0);
    cyc(); chk("c4_dep_inner", q4_inner, 1);
    cyc(); cyc();
    chk("c4_eq2_lock", q4_lock, 10);
    chk("c4_eq2_drain", q4_drain, 1);
    cyc(); chk("c4_down1", q4_lock, 6);
    cyc(); chk("c4_down2", q4_lock, 2);
    cyc(); chk("c4_down_clamp", q4_lock, 1);
    cyc(); chk("c4_outer", q4_outer, 1);
    t4_tick = 0;

    // Arrive transit trace: outside=5, inner=2, tick every cycle.
    tbl[0] = mk(1, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    for (int i = 1; i <= 4; i++) tbl[i] = mk(0, 0, 1, i, 0, 0, 1, 0, 1, 0);
    tbl[5] = mk(0, 0, 1, 5, 0, 0, 1, 0, 0, 0);
    for (int i = 6; i <= 9; i++) tbl[i] = mk(0, 0, 1, 5, 1, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 0, 1, 5, 0, 0, 1, 0, 0, 1);
    tbl[11] = mk(0, 0, 1, 4, 0, 0, 1, 0, 0, 1);
    tbl[12] = mk(0, 0, 1, 3, 0, 0, 1, 0, 0, 1);
    tbl[13] = mk(0, 0, 1, 2, 0, 0, 1, 0, 0, 0);
    for (int i = 14; i <= 17; i++) tbl[i] = mk(0, 0, 1, 2, 0, 1, 1, 0, 0, 0);
    tbl[18] = mk(0, 0, 1, 2, 0, 0, 1, 1, 0, 0);
    tbl[19] = mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      arrive_req = tbl[i].arr; depart_req = tbl[i].dep; tick = tbl[i].tk;
      cyc();
      chk($sformatf("arr%0d_lock", i), lock_level, tbl[i].lock);
      chk($sformatf("arr%0d_outer", i), outer_open, tbl[i].outer);
      chk($sformatf("arr%0d_inner", i), inner_open, tbl[i].inner);
      chk($sformatf("arr%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("arr%0d_done", i), done, tbl[i].dn);
      chk($sformatf("arr%0d_fill", i), filling, tbl[i].fill);
      chk($sformatf("arr%0d_drain", i), draining, tbl[i].drain);
      chk($sformatf("arr%0d_dir", i), dir, 1);
    end

    // Both requests held: grants alternate starting with arrive.
    outside_level = 2; inner_level = 2;
    arrive_req = 1; depart_req = 1;
    for (int t = 0; t < 3; t++) begin
      n = 0;
      while (busy !== 1'b0 && n < 100) begin cyc(); n++; end
      if (n >= 100) timeout("prio_idle");
      n = 0;
      while (busy !== 1'b1 && n < 100) begin cyc(); n++; end
      if (n >= 100) timeout("prio_busy");
      chk($sformatf("prio_dir%0d", t), dir, (t == 1) ? 0 : 1);
      n = 0;
      while (done !== 1'b1 && n < 100) begin cyc(); n++; end
      if (n >= 100) timeout("prio_done");
    end
    arrive_req = 0; depart_req = 0;
    cyc(); cyc();
    chk("prio_no_fourth", busy, 0);

    // Bring the chamber to 9, then a depart with zero initial mismatch.
    outside_level = 9; inner_level = 9;
    arrive_req = 1; cyc(); arrive_req = 0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin cyc(); n++; end
    if (n >= 200) timeout("pre_dep_done");
    cyc();
    outside_level = 3;
    depart_req = 1; cyc(); depart_req = 0;
    chk("dep_busy", busy, 1);
    chk("dep_dir", dir, 0);
    chk("dep_eq_inner", inner_open, 0);
    chk("dep_eq_lock", lock_level, 9);
    cyc(); chk("dep_inner_open", inner_open, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("dep_inner_hold", inner_open, 1);
    end
    cyc();
    chk("dep_inner_closed", inner_open, 0);
    chk("dep_drain_start", draining, 1);
    chk("dep_eq2_lock", lock_level, 9);
    for (int v = 8; v >= 3; v--) begin
      cyc();
      chk($sformatf("dep_lock%0d", v), lock_level, v);
      chk($sformatf("dep_drain%0d", v), draining, (v > 3) ? 1 : 0);
      chk("dep_dir_hold", dir, 0);
    end
    cyc();
    chk("dep_outer_open", outer_open, 1);
    chk("dep_outer_dir", dir, 0);
    n = 0;
    while (done !== 1'b1 && n < 100) begin cyc(); n++; end
    if (n >= 100) timeout("dep_done");
    cyc();

    // Asynchronous reset while the outer port is open at level 7.
    outside_level = 7; inner_level = 7;
    arrive_req = 1; cyc(); arrive_req = 0;
    n = 0;
    while (outer_open !== 1'b1 && n < 100) begin cyc(); n++; end
    if (n >= 100) timeout("ar_outer");
    chk("ar_lock7", lock_level, 7);
    #3 rst = 1;
    #1;
    chk("ar_outer_drop", outer_open, 0);
    chk("ar_busy_drop", busy, 0);
    chk("ar_lock_reset", lock_level, 0);
    chk("ar_inner", inner_open, 0);
    @(posedge clk); #1;
    rst = 0;
    arrive_req = 1; cyc(); arrive_req = 0;
    chk("ar_restart_busy", busy, 1);
    chk("ar_restart_dir", dir, 1);
    chk("ar_restart_outer", outer_open, 0);
    chk("ar_restart_fill", filling, 1);

    // Random phase against the transit model.
    rst = 1; outside_level = 4; inner_level = 8; tick = 1;
    cyc();
    rst = 0;
    fork
      model_run();
    join_none
    for (int c = 0; c < 2500; c++) begin
      int tgt;
      arrive_req = ($urandom_range(0, 3) == 0);
      depart_req = ($urandom_range(0, 3) == 0);
      tick       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) outside_level = LW'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) inner_level = LW'($urandom_range(0, 12));
      cyc();
      tgt = side_lvl(m_dir ^ m_ph2);
      chk("rnd_lock", lock_level, m_lock);
      chk("rnd_outer", outer_open, m_outer);
      chk("rnd_inner", inner_open, m_inner);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_dir", dir, m_dir);
      chk("rnd_done", done, m_done);
      chk("rnd_fill", filling, m_eq && (tgt > m_lock));
      chk("rnd_drain", draining, m_eq && (tgt < m_lock));
      chk("rnd_ports_excl", outer_open & inner_open, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
